// File: rtl/ysyx_22041412_lsu.sv
// Load/store unit: one outstanding access, 64-bit bus, byte-lane store masks, sign/zero-extended loads.
// Optional misalignment trap enabled by defining YSYX_22041412_LSU_MISALIGN_CHK_EN.
`timescale 1ns/1ps
module ysyx_22041412_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] rdata,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CW       = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_t;

    state_t         r_state, w_state_nxt;
    logic [2:0]     r_func3, r_off;
    logic           r_is_store;
    logic [CW-1:0]  r_cnt;
    logic           r_in_ready, r_out_valid, r_mem_req, r_mem_we, r_bus_err, r_misalign;
    logic [63:0]    r_mem_addr, r_mem_wdata, r_rdata;
    logic [7:0]     r_mem_wmask;

    logic           w_is_load, w_is_store, w_illegal, w_misal, w_accept;
    logic [63:0]    w_ld_shift, w_res_data;
    logic           w_done_en, w_res_err, w_res_mis;

    function automatic logic [63:0] ld_extend(input logic [2:0] f3, input logic [63:0] d);
        case (f3)
            3'b000:  ld_extend = {{56{d[7]}},  d[7:0]};
            3'b001:  ld_extend = {{48{d[15]}}, d[15:0]};
            3'b010:  ld_extend = {{32{d[31]}}, d[31:0]};
            3'b011:  ld_extend = d;
            3'b100:  ld_extend = {56'd0, d[7:0]};
            3'b101:  ld_extend = {48'd0, d[15:0]};
            3'b110:  ld_extend = {32'd0, d[31:0]};
            default: ld_extend = 64'd0;
        endcase
    endfunction

    // Lanes shifted past byte 7 fall off the 8-bit result.
    function automatic logic [7:0] st_mask(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'b00:   st_mask = 8'h01 << off;
            2'b01:   st_mask = 8'h03 << off;
            2'b10:   st_mask = 8'h0F << off;
            default: st_mask = 8'hFF;
        endcase
    endfunction

    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (opcode == OP_STORE);
    assign w_illegal  = (w_is_load && (func3 == 3'b111)) || (w_is_store && func3[2]);
    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_ld_shift = mem_rdata >> {r_off, 3'b000};

`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
    assign w_misal = (w_is_load || w_is_store) &&
                     (((func3[1:0] == 2'b01) && (addr[0] != 1'b0)) ||
                      ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                      ((func3[1:0] == 2'b11) && (addr[2:0] != 3'b000)));
`else
    assign w_misal = 1'b0;
`endif

    // Next state plus the result captured on entry to DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_done_en   = 1'b0;
        w_res_data  = 64'd0;
        w_res_err   = 1'b0;
        w_res_mis   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!in_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (!(w_is_load || w_is_store)) begin
                    w_state_nxt = S_DONE;
                    w_done_en   = 1'b1;
                    w_res_data  = addr;
                end else if (w_illegal || w_misal) begin
                    w_state_nxt = S_DONE;
                    w_done_en   = 1'b1;
                    w_res_mis   = w_misal && !w_illegal;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (!mem_gnt) begin
                    w_state_nxt = S_REQ;
                end else if (r_is_store) begin
                    w_state_nxt = S_DONE;
                    w_done_en   = 1'b1;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_DONE;
                    w_done_en   = 1'b1;
                    w_res_data  = ld_extend(r_func3, w_ld_shift);
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_DONE;
                    w_done_en   = 1'b1;
                    w_res_err   = 1'b1;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with all handshake and bus outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_func3     <= 3'd0;
            r_off       <= 3'd0;
            r_is_store  <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 64'd0;
            r_mem_wdata <= 64'd0;
            r_mem_wmask <= 8'd0;
            r_rdata     <= 64'd0;
            r_bus_err   <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_mem_req   <= (w_state_nxt == S_REQ);
            r_mem_we    <= (w_state_nxt == S_REQ) && (w_accept ? w_is_store : r_is_store);
            if ((r_state == S_RESP) && (w_state_nxt == S_RESP)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= {CW{1'b0}};
            end
            if (w_accept) begin
                r_func3    <= func3;
                r_off      <= addr[2:0];
                r_is_store <= w_is_store;
            end
            if (w_accept && (w_state_nxt == S_REQ)) begin
                r_mem_addr  <= {addr[63:3], 3'b000};
                r_mem_wdata <= wdata << {addr[2:0], 3'b000};
                r_mem_wmask <= w_is_store ? st_mask(func3[1:0], addr[2:0]) : 8'd0;
            end
            if (w_done_en) begin
                r_rdata    <= w_res_data;
                r_bus_err  <= w_res_err;
                r_misalign <= w_res_mis;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;
    assign misalign  = r_misalign;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Randomized bench for ysyx_22041412_lsu against an arithmetic reference of the load/store rules.
`timescale 1ns/1ps
module tb_ysyx_22041412_lsu;
    localparam int TO = 4;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  func3 = 3'd0;
    logic [63:0] addr = 64'd0, wdata = 64'd0;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] rdata;
    logic        bus_err, misalign, mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22041412_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .addr(addr), .wdata(wdata),
        .out_valid(out_valid), .out_ready(out_ready), .rdata(rdata),
        .bus_err(bus_err), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64;
        return {$urandom, $urandom};
    endfunction

    // One complete transaction; gd/rd = grant/rvalid wait cycles, to = never answer the load.
    task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] md,
                           input int gd, input int rd, input bit to, input int hold);
        int          kind, n, off, lat, exp_lat;
        logic [63:0] e_rdata, szm, sh;
        logic [15:0] m16;
        logic [7:0]  e_mask;
        logic        e_err, e_mis;
        off = int'(a[2:0]);
        n   = 1 << f3[1:0];
        e_rdata = 64'd0; e_err = 1'b0; e_mis = 1'b0; e_mask = 8'd0;
        if (op != LD && op != ST) begin
            kind = 0; e_rdata = a;
        end else if ((op == LD && f3 == 3'd7) || (op == ST && f3[2])) begin
            kind = 1;
        end else begin
            kind = (op == LD) ? 2 : 3;
`ifdef YSYX_22041412_LSU_MISALIGN_CHK_EN
            if (n > 1 && (off % n) != 0) begin kind = 1; e_mis = 1'b1; end
`endif
        end
        if (kind == 2) begin
            if (to) begin
                e_err = 1'b1;
            end else begin
                sh  = md >> (8 * off);
                szm = (n == 8) ? ~64'd0 : ((64'd1 << (8 * n)) - 64'd1);
                e_rdata = sh & szm;
                if (!f3[2] && n < 8 && sh[8*n-1]) e_rdata = e_rdata | ~szm;
            end
        end
        if (kind == 3) begin
            m16 = ((16'd1 << n) - 16'd1) << off;
            e_mask = (n == 8) ? 8'hFF : m16[7:0];
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; opcode = op; func3 = f3; addr = a; wdata = wd;
        step;
        lat = 1;
        in_valid = 1'b0; opcode = 7'($urandom); func3 = 3'($urandom); addr = rnd64(); wdata = rnd64();
        if (kind >= 2) begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, a & ~64'h7);
            chk("mem_we", mem_we, kind == 3);
            if (kind == 3) begin
                chk("mem_wmask", mem_wmask, e_mask);
                chk("mem_wdata", mem_wdata, wd << (8 * off));
            end
            for (int i = 0; i < gd; i++) begin
                mem_rvalid = 1'b1;
                step; lat++;
                chk("req_hold", mem_req, 1);
            end
            mem_rvalid = 1'b0; mem_gnt = 1'b1;
            step; lat++;
            mem_gnt = 1'b0;
            if (kind == 2) begin
                chk("req_drop", mem_req, 0);
                if (to) begin
                    while (!out_valid && lat < 200) begin step; lat++; end
                end else begin
                    for (int i = 0; i < rd; i++) begin step; lat++; end
                    mem_rvalid = 1'b1; mem_rdata = md;
                    step; lat++;
                    mem_rvalid = 1'b0; mem_rdata = rnd64();
                end
            end
        end else begin
            chk("no_mem_req", mem_req, 0);
        end
        if (kind <= 1)      exp_lat = 1;
        else if (kind == 3) exp_lat = 2 + gd;
        else if (to)        exp_lat = 2 + gd + TO;
        else                exp_lat = 3 + gd + rd;
        chk("latency", lat, exp_lat);
        chk("out_valid", out_valid, 1);
        if (kind != 3) chk("rdata", rdata, e_rdata);
        chk("bus_err", bus_err, e_err);
        chk("misalign", misalign, e_mis);
        for (int i = 0; i < hold; i++) begin
            mem_rvalid = to; mem_rdata = rnd64();
            step;
            mem_rvalid = 1'b0;
            chk("hold_valid", out_valid, 1);
            if (kind != 3) chk("hold_rdata", rdata, e_rdata);
            chk("hold_err", bus_err, e_err);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [5];
        logic [6:0] op;
        logic [2:0] f3;
        logic [63:0] a;
        ops[0] = LD; ops[1] = ST; ops[2] = 7'b0110011; ops[3] = 7'b0010011; ops[4] = 7'b0110111;
        @(negedge clk); step;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_misalign", misalign, 0);

        run_txn(LD, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 0);
        run_txn(ST, 3'b001, 64'h8000_0006, 64'h1234, 64'd0, 0, 0, 1'b0, 0);
        run_txn(7'b0110011, 3'b000, 64'hDEAD, 64'd0, 64'd0, 0, 0, 1'b0, 4);
        run_txn(LD, 3'b011, 64'h1000, 64'd0, rnd64(), 0, 0, 1'b1, 2);
        mem_rvalid = 1'b1; step; mem_rvalid = 1'b0;
        chk("late_rvalid_valid", out_valid, 0);
        chk("late_rvalid_ready", in_ready, 1);
        run_txn(LD, 3'b010, 64'h2, 64'd0, 64'h0000_8765_4321_0000, 0, 0, 1'b0, 0);
        run_txn(LD, 3'b111, 64'h8, 64'd0, 64'd0, 0, 0, 1'b0, 1);
        run_txn(ST, 3'b100, 64'h8, 64'd5, 64'd0, 0, 0, 1'b0, 0);

        in_valid = 1'b1; opcode = LD; func3 = 3'b011; addr = 64'h4000_0010;
        step;
        in_valid = 1'b0;
        chk("rst_mid_req", mem_req, 1);
        rst = 1'b1; step; rst = 1'b0;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        mem_gnt = 1'b1; step; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; step; mem_rvalid = 1'b0;
        chk("rst_late_req", mem_req, 0);
        chk("rst_late_valid", out_valid, 0);

        for (int t = 0; t < 80; t++) begin
            op = ops[$urandom_range(0, 4)];
            f3 = 3'($urandom_range(0, 7));
            a  = rnd64();
            run_txn(op, f3, a, rnd64(), rnd64(), $urandom_range(0, 2), $urandom_range(0, 2),
                    (op == LD) && ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22041412_lsu.md
YSYX_22041412_LSU -- requirements
Module: ysyx_22041412_lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, maximum cycles spent in RESP waiting for mem_rvalid before a bus error is reported.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have: in_valid  in  1  request from execute stage; in_ready  out  1  LSU can accept.
REQ-004 SHALL have: opcode  in  7  instruction opcode; func3  in  3  access size/sign.
REQ-005 SHALL have: addr  in  64  ALU result (effective address or passthrough value); wdata  in  64  store data (rs2).
REQ-006 SHALL have: out_valid  out  1  result available; out_ready  in  1  writeback accepts; rdata  out  64  load/passthrough result; bus_err  out  1  timeout flag; misalign  out  1  misaligned-access flag.
REQ-007 SHALL have: mem_req  out  1; mem_we  out  1; mem_addr  out  64  8-byte aligned; mem_wdata  out  64; mem_wmask  out  8; mem_gnt  in  1; mem_rvalid  in  1; mem_rdata  in  64.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, RESP, DONE; in_ready=1 only in IDLE.
REQ-009 SHALL latch opcode, func3, addr, wdata on in_valid&in_ready.
REQ-010 SHALL, for load (7'b0000011) or store (7'b0100011), go IDLE->REQ; for any other opcode, go IDLE->DONE with rdata=addr (passthrough, latency 1).
REQ-011 SHALL hold mem_req=1 throughout REQ, with mem_addr={addr[63:3],3'b000} and mem_we=1 for store; REQ->RESP (load) or REQ->DONE (store) on mem_gnt.
REQ-012 SHALL leave RESP for DONE on mem_rvalid; mem_rvalid outside RESP SHALL be ignored.
REQ-013 SHALL count RESP cycles; when count reaches TIMEOUT without mem_rvalid -> DONE with bus_err=1, rdata=0.
REQ-014 SHALL hold out_valid=1 and rdata/bus_err/misalign stable in DONE until out_ready; DONE->IDLE on out_ready.
REQ-015 SHALL build store lanes with off=addr[2:0]: sb mask 8'h01<<off, sh 8'h03<<off, sw 8'h0F<<off, sd 8'hFF; mem_wdata=wdata<<(8*off); mask bits shifted past lane 7 dropped.
REQ-016 SHALL form load data as mem_rdata>>(8*off), then extend: 000 lb sign8, 001 lh sign16, 010 lw sign32, 011 ld, 100 lbu, 101 lhu, 110 lwu zero-extend.
REQ-017 SHALL treat load func3=111 or store func3[2]=1 as illegal: no memory request, IDLE->DONE, rdata=0, flags 0.
REQ-018 SHALL register rdata on entry to DONE; latency with mem_gnt and mem_rvalid each one cycle after request: load 3 cycles, store 2 cycles from acceptance to out_valid.

Reset
REQ-019 SHALL, on rst, enter IDLE; in_ready=1 in the following cycle; out_valid, mem_req, mem_we, mem_wmask, mem_addr, mem_wdata, rdata, bus_err, misalign, timeout counter all 0.
REQ-020 SHALL abandon any in-flight transaction on rst mid-operation; mem_req=0 from the cycle after rst; late mem_gnt/mem_rvalid ignored.

Configuration
REQ-021 SHALL, when YSYX_22041412_LSU_MISALIGN_CHK_EN is defined, detect h with addr[0]!=0, w with addr[1:0]!=0, d with addr[2:0]!=0: no memory request, IDLE->DONE, misalign=1, rdata=0.
REQ-022 SHALL, without YSYX_22041412_LSU_MISALIGN_CHK_EN, tie misalign to 0 and issue every access per REQ-015/016 (lanes beyond byte 7 dropped).

Verification
REQ-023 SHALL cover ld/lb sign: addr=0x80000003, lb, mem_rdata=0x00000000_80000000 (byte3=0x80), gnt/rvalid next cycle -> out_valid on cycle 3, rdata=0xFFFFFFFF_FFFFFF80.
REQ-024 SHALL cover store sh: addr=0x80000006, wdata=0x1234 -> mem_addr=0x80000000, mem_wmask=8'hC0, mem_wdata=0x1234_0000_0000_0000, mem_we=1, out_valid on cycle 2.
REQ-025 SHALL cover passthrough: opcode=R-type, addr=0xDEAD -> out_valid next cycle, rdata=0xDEAD, no mem_req; out_ready held 0 for 4 cycles -> outputs stable, in_ready=0.
REQ-026 SHALL cover timeout: TIMEOUT=4, load granted, no mem_rvalid -> out_valid after 4 RESP cycles, bus_err=1, rdata=0; then a late mem_rvalid ignored.
REQ-027 SHALL cover misalign: lw addr=0x2 -> with macro: misalign=1, no mem_req; without macro: mem_wmask N/A, mem_addr=0x0, rdata=mem_rdata[47:16] sign-extended.
REQ-028 SHALL cover reset during REQ with mem_gnt withheld -> mem_req=0 next cycle, in_ready=1, out_valid=0.
